// File: rtl/rf_pkg.sv
// Shared constants and reset-value helper for the scoreboarded register file.
package rf_pkg;

  localparam int RF_DATA_W   = 8;
  localparam int RF_NUM_REGS = 8;

  // Reset contents of register idx: its own index, truncated to width bits.
  function automatic logic [63:0] rf_reset_value(input int idx, input int width);
    logic [63:0] v;
    v = 64'(idx);
    for (int b = 0; b < 64; b++) begin
      if (b >= width) v[b] = 1'b0;
    end
    return v;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: reservation accept, release on writeback, busy count.
// ZERO_REG_EN: reservations of register 0 are accepted but never mark it busy.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int NUM_REGS = RF_NUM_REGS,
  localparam int ADDR_W   = $clog2(NUM_REGS),
  localparam int CNT_W    = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  output logic              rsv_ok,
  output logic [CNT_W-1:0]  busy_cnt
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rsv_set;
  logic                inc;
  logic                dec;
  logic [ADDR_W-1:0]   rd_addr [2];
  logic                rd_busy [2];

  always_comb begin
    rsv_ok = rsv_en && !rst &&
             (!busy_q[rsv_addr] || (wr_en && (wr_addr == rsv_addr)));
`ifdef ZERO_REG_EN
    rsv_set = rsv_ok && (rsv_addr != '0);
`else
    rsv_set = rsv_ok;
`endif
    // Release first so a same-edge reservation of the same register wins.
    busy_d = busy_q;
    if (wr_en)   busy_d[wr_addr]  = 1'b0;
    if (rsv_set) busy_d[rsv_addr] = 1'b1;

    inc = rsv_set && !busy_q[rsv_addr];
    dec = wr_en && busy_q[wr_addr] && !(rsv_set && (rsv_addr == wr_addr));
    cnt_d = cnt_q;
    if (inc && !dec)      cnt_d = cnt_q + CNT_W'(1);
    else if (dec && !inc) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rd_addr[0] = rd_addr_a;
  assign rd_addr[1] = rd_addr_b;

  // A writeback to the addressed register in this cycle clears the hazard.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd_busy
    assign rd_busy[gi] = busy_q[rd_addr[gi]] && !(wr_en && (wr_addr == rd_addr[gi]));
  end

  assign rd_busy_a = rd_busy[0];
  assign rd_busy_b = rd_busy[1];
  assign busy_cnt  = cnt_q;

endmodule

// File: rtl/rf_scoreboard_regfile.sv
// NUM_REGS x DATA_W register file, two bypassed read ports, busy scoreboard.
// ZERO_REG_EN: register 0 is hardwired to zero (writes dropped, never busy).
module rf_scoreboard_regfile
  import rf_pkg::*;
#(
  parameter  int DATA_W   = RF_DATA_W,
  parameter  int NUM_REGS = RF_NUM_REGS,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ok,
  output logic [ADDR_W:0]   busy_cnt
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic              wr_eff;
  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];

`ifdef ZERO_REG_EN
  assign wr_eff = wr_en && (wr_addr != '0);
`else
  assign wr_eff = wr_en;
`endif

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic we;
    assign we = wr_eff && (wr_addr == ADDR_W'(gi));
    always_ff @(posedge clk or posedge rst) begin
      if (rst)     mem_q[gi] <= DATA_W'(rf_reset_value(gi, DATA_W));
      else if (we) mem_q[gi] <= wr_data;
    end
  end

  assign rd_addr[0] = rd_addr_a;
  assign rd_addr[1] = rd_addr_b;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    always_comb begin
      rd_data[gi] = mem_q[rd_addr[gi]];
      if (wr_eff && (wr_addr == rd_addr[gi])) rd_data[gi] = wr_data;
`ifdef ZERO_REG_EN
      if (rd_addr[gi] == '0) rd_data[gi] = '0;
`endif
    end
  end

  assign rd_data_a = rd_data[0];
  assign rd_data_b = rd_data[1];

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_eff),
    .wr_addr   (wr_addr),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_busy_a (rd_busy_a),
    .rd_busy_b (rd_busy_b),
    .rsv_ok    (rsv_ok),
    .busy_cnt  (busy_cnt)
  );

endmodule

// File: tb/tb_rf_scoreboard_regfile.sv
// Directed bench for rf_scoreboard_regfile with hand-computed expectations.
module tb_rf_scoreboard_regfile;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rd_addr_a, rd_addr_b;
  logic [7:0] rd_data_a, rd_data_b;
  logic       rd_busy_a, rd_busy_b;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       rsv_en;
  logic [2:0] rsv_addr;
  logic       rsv_ok;
  logic [3:0] busy_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rf_scoreboard_regfile dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .rd_busy_a (rd_busy_a),
    .rd_busy_b (rd_busy_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .rsv_ok    (rsv_ok),
    .busy_cnt  (busy_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  // Advance past the next rising edge; inputs change 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = 1'b0;
    rsv_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; rd_addr_a = '0; rd_addr_b = '0;
    step(); step();

    // Requests during reset are refused and ignored.
    rsv_en = 1'b1; rsv_addr = 3'd4; wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'hEE;
    #1 check("rsv_ok_in_reset", rsv_ok, 0);
    step();
    idle();
    check("cnt_in_reset", busy_cnt, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i);
      #1;
      check($sformatf("rst_data_a[%0d]", i), rd_data_a, i);
      check($sformatf("rst_data_b[%0d]", 7 - i), rd_data_b, 7 - i);
      check($sformatf("rst_busy_a[%0d]", i), rd_busy_a, 0);
    end
    check("rst_cnt", busy_cnt, 0);

    // Write with same-cycle bypass.
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5; rd_addr_a = 3'd3; rd_addr_b = 3'd2;
    #1 check("bypass_a", rd_data_a, 8'hA5);
    check("nobypass_b", rd_data_b, 8'h02);
    step(); idle();
    #1 check("written_a", rd_data_a, 8'hA5);

    // Scoreboard handshake on register 5.
    rsv_en = 1'b1; rsv_addr = 3'd5; rd_addr_a = 3'd5;
    #1 check("rsv5_ok", rsv_ok, 1);
    check("rsv5_busy_before", rd_busy_a, 0);
    step(); idle();
    #1 check("rsv5_busy", rd_busy_a, 1);
    check("rsv5_cnt", busy_cnt, 1);
    rsv_en = 1'b1; rsv_addr = 3'd5;
    #1 check("rsv5_again_ok", rsv_ok, 0);
    rsv_en = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h3C;
    #1 check("wr5_busy_same_cycle", rd_busy_a, 0);
    check("wr5_bypass", rd_data_a, 8'h3C);
    check("wr5_cnt_before", busy_cnt, 1);
    step(); idle();
    #1 check("wr5_cnt_after", busy_cnt, 0);
    check("wr5_busy_after", rd_busy_a, 0);
    check("wr5_data", rd_data_a, 8'h3C);

    // Write and reserve register 2 on one edge while it is busy.
    rsv_en = 1'b1; rsv_addr = 3'd2;
    step(); idle();
    rd_addr_a = 3'd2;
    #1 check("rsv2_cnt", busy_cnt, 1);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h5A; rsv_en = 1'b1; rsv_addr = 3'd2;
    #1 check("wr_rsv2_ok", rsv_ok, 1);
    step(); idle();
    #1 check("wr_rsv2_data", rd_data_a, 8'h5A);
    check("wr_rsv2_busy", rd_busy_a, 1);
    check("wr_rsv2_cnt", busy_cnt, 1);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h11;
    step(); idle();
    #1 check("rel2_cnt", busy_cnt, 0);

    // Release 4 while reserving 6.
    rsv_en = 1'b1; rsv_addr = 3'd4;
    step(); idle();
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h44; rsv_en = 1'b1; rsv_addr = 3'd6;
    #1 check("rsv6_ok", rsv_ok, 1);
    step(); idle();
    rd_addr_a = 3'd4; rd_addr_b = 3'd6;
    #1 check("swap_cnt", busy_cnt, 1);
    check("swap_busy4", rd_busy_a, 0);
    check("swap_busy6", rd_busy_b, 1);
    check("swap_data4", rd_data_a, 8'h44);

    // Write to a free register leaves the count alone.
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h77;
    step(); idle();
    rd_addr_a = 3'd1;
    #1 check("free_wr_cnt", busy_cnt, 1);
    check("free_wr_data", rd_data_a, 8'h77);

    // Fill the scoreboard.
    for (int i = 0; i < 8; i++) begin
      rsv_en = 1'b1; rsv_addr = 3'(i);
      #1 check($sformatf("fill_ok[%0d]", i), rsv_ok, (i == 6) ? 0 : 1);
      step();
    end
    idle();
`ifdef ZERO_REG_EN
    #1 check("full_cnt", busy_cnt, 7);
`else
    #1 check("full_cnt", busy_cnt, 8);
`endif

    // Mid-operation asynchronous reset between edges.
    #2 rst = 1'b1;
    #1 check("midrst_cnt", busy_cnt, 0);
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i);
      #1 check($sformatf("midrst_data[%0d]", i), rd_data_a, i);
      check($sformatf("midrst_busy[%0d]", i), rd_busy_a, 0);
    end
    rsv_en = 1'b1; rsv_addr = 3'd3;
    #1 check("midrst_rsv_ok", rsv_ok, 0);
    step();
    rst = 1'b0;
    #1 check("post_rst_rsv_ok", rsv_ok, 1);
    step(); idle();
    #1 check("post_rst_cnt", busy_cnt, 1);

    // Register 0 behaviour.
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hFF; rd_addr_a = 3'd0;
`ifdef ZERO_REG_EN
    #1 check("r0_no_bypass", rd_data_a, 0);
    step(); idle();
    #1 check("r0_read", rd_data_a, 0);
    rsv_en = 1'b1; rsv_addr = 3'd0;
    #1 check("r0_rsv_ok", rsv_ok, 1);
    step(); idle();
    #1 check("r0_busy", rd_busy_a, 0);
    check("r0_cnt", busy_cnt, 1);
`else
    #1 check("r0_bypass", rd_data_a, 8'hFF);
    step(); idle();
    #1 check("r0_read", rd_data_a, 8'hFF);
    rsv_en = 1'b1; rsv_addr = 3'd0;
    #1 check("r0_rsv_ok", rsv_ok, 1);
    step(); idle();
    #1 check("r0_busy", rd_busy_a, 1);
    check("r0_cnt", busy_cnt, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_scoreboard_regfile.md
# rf_scoreboard_regfile

Parametrised successor to the processor's 8x8 register file: NUM_REGS x DATA_W storage, two combinational read ports with same-cycle write bypass, and a per-register busy scoreboard for a pipelined core. The issue stage reserves a destination register. Writeback writes the register and releases the reservation. Decode uses the per-port busy flags to stall on RAW hazards.

## Interface
- DATA_W, 8, register width in bits
- NUM_REGS, 8, number of registers; power of two, at least 2
- ADDR_W, $clog2(NUM_REGS), register index width; derived, not overridden
- clk  in  1  clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-high reset
- rd_addr_a, rd_addr_b  in  ADDR_W  read port indices
- rd_data_a, rd_data_b  out  DATA_W  read data (combinational)
- rd_busy_a, rd_busy_b  out  1  the addressed register has a pending write
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_W  writeback index
- wr_data  in  DATA_W  writeback data
- rsv_en  in  1  reservation request from issue
- rsv_addr  in  ADDR_W  register to reserve
- rsv_ok  out  1  the reservation is accepted this cycle
- busy_cnt  out  ADDR_W+1  number of currently reserved registers

## Operation
- Reset asserted, asynchronously: register i is loaded with i truncated to DATA_W, so register 0 holds 0 and register 7 holds 7. All busy bits and busy_cnt are cleared.
- While Reset is high, wr_en and rsv_en are ignored and rsv_ok is 0.
- Write: on a clk edge with wr_en=1, mem[wr_addr] <= wr_data and busy[wr_addr] <= 0.
- A write to a register that is not busy is legal. It updates the data, and busy_cnt is unchanged.
- Read: rd_data_x = mem[rd_addr_x].
  - Bypass: if wr_en=1 and wr_addr==rd_addr_x, rd_data_x = wr_data in the same cycle.
- rd_busy_x = busy[rd_addr_x] AND NOT (wr_en AND wr_addr==rd_addr_x). A same-cycle writeback therefore resolves the hazard.
- rsv_ok = rsv_en AND NOT Reset AND (NOT busy[rsv_addr] OR (wr_en AND wr_addr==rsv_addr)).
- At most one outstanding producer per register, so WAW is impossible. If rsv_en=1 and rsv_ok=0, the issuer holds its request.
- Accepted reservation: busy[rsv_addr] <= 1 on the edge.
  - If the same edge also writes the same address, the reservation wins: data is written and busy stays 1.
- busy_cnt changes per edge as follows:
  - +1 for an accepted reservation of a free register.
  - -1 for a write to a busy register.
  - 0 when both hit the same register.
  - 0 when one reservation and one release hit different registers.
  - It never wraps; its maximum is NUM_REGS.

## Timing
- Reads, bypass, rd_busy and rsv_ok are combinational, with zero-cycle latency.
- A write is visible in mem, and a busy change is visible on rd_busy, from the cycle after the edge.
- Reset deasserted mid-operation: the first edge after deassertion is the first that can write or reserve.
- Reset asserted mid-operation discards all pending reservations at once.

## Configuration
- ZERO_REG_EN defined (RISC-V x0 behaviour):
  - register 0 always reads 0, and the bypass never applies to address 0;
  - writes to address 0 are discarded;
  - rd_busy for address 0 is always 0;
  - a reservation of address 0 gives rsv_ok=1 but sets no busy bit and leaves busy_cnt unchanged.
- ZERO_REG_EN undefined: register 0 behaves exactly like every other register, with reset value 0.

## Structure
- The shared package rf_pkg holds the default DATA_W and NUM_REGS constants and a function giving the reset value of register i truncated to a width.
- There is one sub-module, rf_scoreboard. It holds the busy vector, busy_cnt, the rsv_ok logic and the rd_busy lookups.
- Storage, read muxes and bypass stay in the top level.

## Test plan
- Reset check (defaults): assert Reset, then release it, and read all 8 addresses. Required: rd_data = 0..7, every rd_busy = 0, busy_cnt = 0.
- Write and bypass: wr_en=1, wr_addr=3, wr_data=0xA5, rd_addr_a=3 in the same cycle. Required: rd_data_a=0xA5 before the edge and still 0xA5 after it with wr_en=0.
- Scoreboard handshake:
  - Reserve 5: rsv_ok=1, and the next cycle shows rd_busy=1 for 5 and busy_cnt=1.
  - Reserve 5 again: rsv_ok=0.
  - Write 5=0x3C: rd_busy for 5 drops in the same cycle, and busy_cnt=0 after the edge.
- Simultaneous events:
  - With 2 busy, write 2 and reserve 2 on one edge. Required: rsv_ok=1, mem[2] updated, 2 still busy, busy_cnt unchanged.
  - Write 4 (busy) while reserving 6 (free). Required: busy_cnt unchanged.
- Full scoreboard and mid-operation reset:
  - Reserve all 8 registers. Required: busy_cnt=8.
  - Assert Reset between edges. Required: busy_cnt=0 immediately and contents back to 0..7.
- With ZERO_REG_EN: write 0=0xFF, then read 0. Required: 0. Reserving 0 gives rsv_ok=1, rd_busy stays 0 for address 0, and busy_cnt stays 0.
